// File: rtl/tone_sequencer_if.sv
// ---------------------------------------------------------------------------
// tone_sequencer_if
// Groups the control inputs and tone outputs of tone_sequencer.
//   sw_code     : manual note code (4 bits)
//   play / stop : playback start / abort requests, level-sampled
//   loop_en     : repeat the scale forever when set
//   busy        : sequence running (NOTE or GAP)
//   note_idx    : current scale index, 0=DO1 .. 7=DO2
//   half_period : current toggle interval in cycles, 0 = silent
//   tone_out    : square-wave drive bit
//   done        : single-cycle pulse at the end of a non-looping sequence
// master = controller side (drives requests), slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface tone_sequencer_if;
    logic [3:0]  sw_code;
    logic        play;
    logic        stop;
    logic        loop_en;
    logic        busy;
    logic [2:0]  note_idx;
    logic [31:0] half_period;
    logic        tone_out;
    logic        done;

    modport master (
        output sw_code, play, stop, loop_en,
        input  busy, note_idx, half_period, tone_out, done
    );

    modport slave (
        input  sw_code, play, stop, loop_en,
        output busy, note_idx, half_period, tone_out, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// ---------------------------------------------------------------------------
// tone_sequencer
// Note sequencer and square-wave tone generator for the DE1-SoC player.
// In IDLE the switch code selects a tone directly; a play request steps
// through the DO1..DO2 scale, each note sounding NOTE_TICKS cycles followed
// by GAP_TICKS silent cycles.
// Ports:
//   clk_in  : system clock
//   reset_n : synchronous active-low reset
//   bus     : tone_sequencer_if.slave (requests in, tone/status out)
// ---------------------------------------------------------------------------
module tone_sequencer #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned NOTE_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 2_500_000
) (
    input  logic             clk_in,
    input  logic             reset_n,
    tone_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    localparam int unsigned FREQ_HZ [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};
    localparam logic [31:0] NOTE_LAST  = 32'(NOTE_TICKS - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_TICKS - 1);

    // Half-period divider per scale index, derived from the clock rate.
    logic [31:0] scale_tbl [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_scale
            assign scale_tbl[gi] = 32'((CLK_HZ / FREQ_HZ[gi]) / 2);
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [31:0] tick_reg, tick_next;
    logic [2:0]  idx_reg, idx_next;
    logic [31:0] hp_reg, hp_next;
    logic        done_reg, done_next;
    logic [31:0] tone_cnt_reg;
    logic        tone_reg;

    logic [31:0] sw_hp;
    logic [2:0]  idx_inc;
    logic [31:0] tick_inc;

    assign idx_inc  = idx_reg + 3'd1;
    // Saturate rather than wrap so a stuck state can never alias a terminal count.
    assign tick_inc = (tick_reg == 32'hFFFF_FFFF) ? tick_reg : tick_reg + 32'd1;

    // Manual switch decode; codes outside the table are silence.
    always_comb begin
        sw_hp = '0;
        case (bus.sw_code)
            4'b0001: sw_hp = scale_tbl[0];
            4'b0011: sw_hp = scale_tbl[1];
            4'b0101: sw_hp = scale_tbl[2];
            4'b1001: sw_hp = scale_tbl[3];
            4'b0111: sw_hp = scale_tbl[4];
            4'b1011: sw_hp = scale_tbl[5];
            4'b1101: sw_hp = scale_tbl[6];
            4'b1111: sw_hp = scale_tbl[7];
            default: sw_hp = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg;
        idx_next   = idx_reg;
        hp_next    = hp_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                hp_next   = sw_hp;
                idx_next  = 3'd0;
                tick_next = '0;
                if (bus.play && !bus.stop) begin
                    state_next = NOTE;
                    hp_next    = scale_tbl[0];
                end
            end

            NOTE: begin
                if (bus.stop) begin
                    state_next = IDLE;
                    idx_next   = 3'd0;
                    hp_next    = '0;
                    tick_next  = '0;
                end else if (tick_reg == NOTE_LAST) begin
                    state_next = GAP;
                    hp_next    = '0;
                    tick_next  = '0;
                end else begin
                    tick_next = tick_inc;
                end
            end

            GAP: begin
                // stop wins over the end-of-gap transition, including the final one.
                if (bus.stop) begin
                    state_next = IDLE;
                    idx_next   = 3'd0;
                    hp_next    = '0;
                    tick_next  = '0;
                end else if (tick_reg == GAP_LAST) begin
                    tick_next = '0;
                    if (idx_reg != 3'd7) begin
                        state_next = NOTE;
                        idx_next   = idx_inc;
                        hp_next    = scale_tbl[idx_inc];
                    end else if (bus.loop_en) begin
                        state_next = NOTE;
                        idx_next   = 3'd0;
                        hp_next    = scale_tbl[0];
                    end else begin
                        state_next = IDLE;
                        idx_next   = 3'd0;
                        hp_next    = '0;
                        done_next  = 1'b1;
                    end
                end else begin
                    tick_next = tick_inc;
                end
            end

            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
                hp_next    = '0;
                tick_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            idx_reg   <= 3'd0;
            hp_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            idx_reg   <= idx_next;
            hp_reg    <= hp_next;
            done_reg  <= done_next;
        end
    end

    // Tone generator. A new divider value restarts the wave low on the same
    // edge it is loaded, so the first rising edge lands half_period cycles later.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            tone_cnt_reg <= '0;
            tone_reg     <= 1'b0;
        end else if (hp_next != hp_reg) begin
            tone_cnt_reg <= '0;
            tone_reg     <= 1'b0;
        end else if (hp_reg == 32'd0) begin
            tone_cnt_reg <= '0;
            tone_reg     <= 1'b0;
        end else if (tone_cnt_reg == hp_reg - 32'd1) begin
            tone_cnt_reg <= '0;
            tone_reg     <= ~tone_reg;
        end else begin
            tone_cnt_reg <= tone_cnt_reg + 32'd1;
        end
    end

    assign bus.busy        = (state_reg != IDLE);
    assign bus.note_idx    = idx_reg;
    assign bus.half_period = hp_reg;
    assign bus.tone_out    = tone_reg;
    assign bus.done        = done_reg;

endmodule
